// File: rtl/str_deci_pkg.sv
// Shared types and helpers for the time-shared decimation scheduler.
package str_deci_pkg;
  localparam int DEF_DW  = 32;
  localparam int DEF_NCH = 4;
  localparam int DEF_CW  = 8;
  localparam int CHW     = $clog2(DEF_NCH);

  typedef logic [DEF_CW-1:0] ratio_t;

  // A ratio of zero would never wrap the phase counter, so it behaves as 1.
  function automatic ratio_t eff_ratio(input ratio_t r);
    return (r == '0) ? ratio_t'(1) : r;
  endfunction
endpackage

// File: rtl/str_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module str_rr_arb #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         gnt,
  output logic [$clog2(NCH)-1:0] gnt_idx
);
  localparam int IW = $clog2(NCH);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/str_deci_sched.sv
// Merges NCH valid/ready streams, keeping one sample in every ratio[c] per
// channel, and forwards kept samples tagged with their source channel.
module str_deci_sched
  import str_deci_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0][DW-1:0]     in_data,
  input  logic [NCH-1:0]             in_valid,
  output logic [NCH-1:0]             in_ready,
  input  logic [NCH-1:0]             enable,
  input  logic [NCH-1:0][CW-1:0]     ratio,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NCH)-1:0]     out_ch,
  output logic                       out_valid,
  input  logic                       out_ready
);
  localparam int IW = $clog2(NCH);

  logic [NCH-1:0][CW-1:0] phase, phase_nxt;
  logic [NCH-1:0][CW-1:0] rlat, rlat_nxt;
  logic [IW-1:0]          ptr;
  logic [NCH-1:0]         req, gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   slot_free, xfer, keep;

  assign slot_free = !out_valid || out_ready;

  // A channel whose next sample will be dropped never waits on the output slot.
  always_comb begin
    req = '0;
    for (int c = 0; c < NCH; c++)
      req[c] = rst_n && in_valid[c] && enable[c] && ((phase[c] != '0) || slot_free);
  end

  str_rr_arb #(.NCH(NCH)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;
  assign xfer     = |gnt;
  assign keep     = xfer && (phase[gnt_idx] == '0);

  // The ratio latched on a kept transfer already governs that transfer's phase step.
  always_comb begin
    phase_nxt = phase;
    rlat_nxt  = rlat;
    for (int c = 0; c < NCH; c++) begin
      if (!enable[c]) begin
        phase_nxt[c] = '0;
      end else if (gnt[c]) begin
        if (phase[c] == '0)
          rlat_nxt[c] = CW'(eff_ratio(ratio_t'(ratio[c])));
        phase_nxt[c] = (phase[c] == rlat_nxt[c] - 1'b1) ? '0 : phase[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      for (int c = 0; c < NCH; c++)
        rlat[c] <= CW'(1);
      ptr <= '0;
    end else begin
      phase <= phase_nxt;
      rlat  <= rlat_nxt;
      if (xfer)
        ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Output slot: load on a kept transfer, otherwise drain on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (keep) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx];
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_str_deci_sched.sv
// Directed bench for str_deci_sched with hand-computed expectations.
module tb_str_deci_sched;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NCH-1:0][DW-1:0] in_data;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [NCH-1:0]         enable;
  logic [NCH-1:0][CW-1:0] ratio;
  logic [DW-1:0]          out_data;
  logic [1:0]             out_ch;
  logic                   out_valid;
  logic                   out_ready;

  int ncmp  = 0;
  int nfail = 0;

  str_deci_sched #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enable    (enable),
    .ratio     (ratio),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int kept;
  int expk;
  int cnt [4];
  int rv  [4];

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '1;
    enable    = '1;
    ratio     = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    tick();
    rst_n    = 1'b1;
    in_valid = '0;
    enable   = '0;

    // Single channel, ratio 5, counting data.
    enable   = 4'b0001;
    in_valid = 4'b0001;
    ratio[0] = 8'd5;
    kept     = 0;
    for (int n = 0; n < 20; n++) begin
      in_data[0] = 32'(n);
      #1;
      check("a_ready", 32'(in_ready), 1);
      tick();
      expk = (n % 5 == 0) ? 1 : 0;
      check("a_valid", 32'(out_valid), 32'(expk));
      if (out_valid) begin
        kept++;
        check("a_data", out_data, 32'(n));
        check("a_ch", 32'(out_ch), 0);
      end
    end
    check("a_kept", 32'(kept), 4);

    // Four channels, ratios 1/2/3/4, round-robin order.
    rst_pulse();
    enable   = 4'b1111;
    in_valid = 4'b1111;
    ratio[0] = 8'd1; ratio[1] = 8'd2; ratio[2] = 8'd3; ratio[3] = 8'd4;
    rv = '{1, 2, 3, 4};
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < NCH; k++)
        in_data[k] = 32'(k * 1000 + i);
      #1;
      check("b_gnt", 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      expk = (((i / 4) % rv[i % 4]) == 0) ? 1 : 0;
      check("b_valid", 32'(out_valid), 32'(expk));
      if (out_valid) begin
        cnt[out_ch]++;
        check("b_ch", 32'(out_ch), 32'(i % 4));
        check("b_data", out_data, 32'((i % 4) * 1000 + i));
      end
    end
    check("b_cnt0", 32'(cnt[0]), 6);
    check("b_cnt1", 32'(cnt[1]), 3);
    check("b_cnt2", 32'(cnt[2]), 2);
    check("b_cnt3", 32'(cnt[3]), 2);

    // Output stall: drops on ch1 keep flowing, ch0 waits.
    rst_pulse();
    enable     = 4'b0011;
    in_valid   = 4'b0011;
    ratio[0]   = 8'd1;
    ratio[1]   = 8'd4;
    in_data[0] = 32'hC0C0_0000;
    in_data[1] = 32'hC1C1_0000;
    out_ready  = 1'b1;
    #1;
    check("c_ready0", 32'(in_ready), 1);
    tick();
    check("c_ch0", 32'(out_ch), 0);
    #1;
    check("c_ready1", 32'(in_ready), 2);
    tick();
    check("c_ch1", 32'(out_ch), 1);
    out_ready = 1'b0;
    for (int s = 0; s < 20; s++) begin
      #1;
      check("c_stall_ready", 32'(in_ready), (s < 3) ? 2 : 0);
      tick();
      check("c_stall_valid", 32'(out_valid), 1);
      check("c_stall_data", out_data, 32'hC1C1_0000);
      check("c_stall_ch", 32'(out_ch), 1);
    end
    out_ready = 1'b1;
    #1;
    check("c_release_ready", 32'(in_ready), 1);
    tick();
    check("c_release_valid", 32'(out_valid), 1);
    check("c_release_ch", 32'(out_ch), 0);
    check("c_release_data", out_data, 32'hC0C0_0000);

    // Ratio change 3 -> 6 mid-frame takes effect at the next frame.
    rst_pulse();
    enable   = 4'b0001;
    in_valid = 4'b0001;
    ratio[0] = 8'd3;
    for (int t = 0; t < 17; t++) begin
      if (t == 1) ratio[0] = 8'd6;
      in_data[0] = 32'(100 + t);
      #1;
      tick();
      expk = (t == 0 || t == 3 || t == 9 || t == 15) ? 1 : 0;
      check("d_valid", 32'(out_valid), 32'(expk));
      if (expk == 1)
        check("d_data", out_data, 32'(100 + t));
    end

    // Ratio 0 behaves as 1.
    rst_pulse();
    enable   = 4'b0100;
    in_valid = 4'b0100;
    ratio[2] = 8'd0;
    for (int t = 0; t < 6; t++) begin
      in_data[2] = 32'(200 + t);
      #1;
      check("e_ready", 32'(in_ready), 4);
      tick();
      check("e_valid", 32'(out_valid), 1);
      check("e_ch", 32'(out_ch), 2);
      check("e_data", out_data, 32'(200 + t));
    end

    // Disable ch1 at phase 2, re-enable: next sample is kept.
    enable     = 4'b0010;
    in_valid   = 4'b0010;
    ratio[1]   = 8'd4;
    in_data[1] = 32'h1111_0000;
    #1;
    check("f_ready0", 32'(in_ready), 2);
    tick();
    check("f_keep0", 32'(out_valid), 1);
    in_data[1] = 32'h1111_0001;
    #1;
    check("f_ready1", 32'(in_ready), 2);
    tick();
    check("f_drop1", 32'(out_valid), 0);
    enable = 4'b0000;
    #1;
    check("f_dis_ready", 32'(in_ready), 0);
    tick();
    check("f_dis_valid", 32'(out_valid), 0);
    enable     = 4'b0010;
    in_data[1] = 32'h1111_0002;
    #1;
    check("f_reen_ready", 32'(in_ready), 2);
    tick();
    check("f_reen_valid", 32'(out_valid), 1);
    check("f_reen_data", out_data, 32'h1111_0002);
    check("f_reen_ch", 32'(out_ch), 1);

    // Mid-stream asynchronous reset clears the slot at once.
    #1;
    rst_n = 1'b0;
    #1;
    check("g_valid", 32'(out_valid), 0);
    check("g_data", out_data, 0);
    check("g_ch", 32'(out_ch), 0);
    check("g_ready", 32'(in_ready), 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("g_after_valid", 32'(out_valid), 1);
    check("g_after_data", out_data, 32'h1111_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
